// File: rtl/v_port_group_sequencer_if.sv
// Handshake and beat bundle between a port allocator and one
// write-port group sequencer of the vector core.
interface v_port_group_sequencer_if #(
    parameter int LANES  = 8,
    parameter int VLEN   = 1024,
    parameter int VL_W   = 11,
    parameter int ADDR_W = $clog2(32 * (VLEN / (32 * LANES)))
);
    localparam int ROW_BYTES = LANES * 4;

    logic                 start_i;
    logic [4:0]           vs1_i;
    logic [4:0]           vs2_i;
    logic [4:0]           vd_i;
    logic [VL_W-1:0]      vl_i;
    logic [1:0]           sew_i;
    logic                 stall_i;
    logic                 port_rdy_o;
    logic                 rd_vld_o;
    logic [ADDR_W-1:0]    rd_vs1_addr_o;
    logic [ADDR_W-1:0]    rd_vs2_addr_o;
    logic                 wr_vld_o;
    logic [ADDR_W-1:0]    wr_addr_o;
    logic [ROW_BYTES-1:0] wr_bmask_o;

    modport master (
        output start_i, vs1_i, vs2_i, vd_i, vl_i, sew_i, stall_i,
        input  port_rdy_o, rd_vld_o, rd_vs1_addr_o, rd_vs2_addr_o,
        input  wr_vld_o, wr_addr_o, wr_bmask_o
    );

    modport slave (
        input  start_i, vs1_i, vs2_i, vd_i, vl_i, sew_i, stall_i,
        output port_rdy_o, rd_vld_o, rd_vs1_addr_o, rd_vs2_addr_o,
        output wr_vld_o, wr_addr_o, wr_bmask_o
    );
endinterface

// File: rtl/v_port_group_sequencer.sv
// Walks the VRF rows of one operand register group, issuing read beats
// and the matching masked write beats PIPE_LAT beats later.
module v_port_group_sequencer #(
    parameter int LANES    = 8,
    parameter int VLEN     = 1024,
    parameter int PIPE_LAT = 3,
    parameter int VL_W     = 11,
    parameter int ADDR_W   = $clog2(32 * (VLEN / (32 * LANES)))
) (
    input logic clk,
    input logic rstn,
    v_port_group_sequencer_if.slave bus
);
    localparam int ROW_BYTES    = LANES * 4;
    localparam int ROWS_PER_REG = VLEN / (8 * ROW_BYTES);
    localparam int RB_SH        = $clog2(ROW_BYTES);
    localparam int TB_W         = VL_W + 3;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [PIPE_LAT-1:0] SR_LOW = {PIPE_LAT{1'b1}} >> 1;

    logic [1:0]           state;
    logic [ADDR_W-1:0]    vs1_base;
    logic [ADDR_W-1:0]    vs2_base;
    logic [ADDR_W-1:0]    vd_base;
    logic [TB_W-1:0]      nrows;
    logic [TB_W-1:0]      r;
    logic [ROW_BYTES-1:0] last_mask;
    logic [PIPE_LAT-1:0]  sr_vld;
    logic [PIPE_LAT-1:0]  sr_last;
    logic [ADDR_W-1:0]    sr_addr [PIPE_LAT];

    logic [1:0]           sew_eff;
    logic [TB_W-1:0]      tb_bytes;
    logic [TB_W-1:0]      nrows_c;
    logic [RB_SH:0]       lb_c;
    logic [ROW_BYTES-1:0] mask_c;
    logic [ADDR_W-1:0]    r_lo;
    logic                 idle;
    logic                 start_ok;
    logic                 rd_active;
    logic                 rd_last;
    logic                 wr_active;
    logic                 sr_busy;

    // Operand geometry, evaluated from the live inputs at start time
    always_comb begin
        sew_eff  = (bus.sew_i == 2'd3) ? 2'd2 : bus.sew_i;
        tb_bytes = TB_W'(bus.vl_i) << sew_eff;
        nrows_c  = (tb_bytes + TB_W'(ROW_BYTES - 1)) >> RB_SH;
        if (tb_bytes[RB_SH-1:0] == '0)
            lb_c = (RB_SH + 1)'(ROW_BYTES);
        else
            lb_c = {1'b0, tb_bytes[RB_SH-1:0]};
        mask_c = '0;
        for (int i = 0; i < ROW_BYTES; i++)
            mask_c[i] = ((RB_SH + 1)'(i) < lb_c);
    end

    assign r_lo      = r[ADDR_W-1:0];
    assign idle      = (state == S_IDLE);
    assign start_ok  = idle && !bus.stall_i && bus.start_i;
    assign rd_active = (state == S_READ) && !bus.stall_i;
    assign rd_last   = (r == nrows - TB_W'(1));
    assign wr_active = sr_vld[PIPE_LAT-1] && !bus.stall_i;
    assign sr_busy   = |(sr_vld & SR_LOW);

    assign bus.port_rdy_o    = idle && !bus.stall_i;
    assign bus.rd_vld_o      = rd_active;
    assign bus.rd_vs1_addr_o = rd_active ? vs1_base + r_lo : '0;
    assign bus.rd_vs2_addr_o = rd_active ? vs2_base + r_lo : '0;
    assign bus.wr_vld_o      = wr_active;
    assign bus.wr_addr_o     = wr_active ? sr_addr[PIPE_LAT-1] : '0;

    always_comb begin
        bus.wr_bmask_o = '0;
        if (wr_active)
            bus.wr_bmask_o = sr_last[PIPE_LAT-1] ? last_mask : '1;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= S_IDLE;
            vs1_base  <= '0;
            vs2_base  <= '0;
            vd_base   <= '0;
            nrows     <= '0;
            r         <= '0;
            last_mask <= '0;
            sr_vld    <= '0;
            sr_last   <= '0;
            for (int i = 0; i < PIPE_LAT; i++)
                sr_addr[i] <= '0;
        end else if (!bus.stall_i) begin
            // Write-side delay line tracks every read beat
            for (int i = PIPE_LAT - 1; i > 0; i--) begin
                sr_vld[i]  <= sr_vld[i-1];
                sr_last[i] <= sr_last[i-1];
                sr_addr[i] <= sr_addr[i-1];
            end
            sr_vld[0]  <= (state == S_READ);
            sr_last[0] <= rd_last;
            sr_addr[0] <= vd_base + r_lo;

            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        vs1_base  <= ADDR_W'(int'(bus.vs1_i) * ROWS_PER_REG);
                        vs2_base  <= ADDR_W'(int'(bus.vs2_i) * ROWS_PER_REG);
                        vd_base   <= ADDR_W'(int'(bus.vd_i) * ROWS_PER_REG);
                        nrows     <= nrows_c;
                        last_mask <= mask_c;
                        r         <= '0;
                        state     <= (bus.vl_i == '0) ? S_DRAIN : S_READ;
                    end
                end
                S_READ: begin
                    r <= r + TB_W'(1);
                    if (rd_last)
                        state <= S_DRAIN;
                end
                S_DRAIN: begin
                    // Only the head stage may still hold a beat; it leaves now
                    if (!sr_busy)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_v_port_group_sequencer.sv
// Directed and random operations against a beat-timeline reference model.
module tb_v_port_group_sequencer;
    localparam int PIPE_LAT = 3;
    localparam int RPR      = 4;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    v_port_group_sequencer_if bus ();

    v_port_group_sequencer #(
        .LANES(8), .VLEN(1024), .PIPE_LAT(PIPE_LAT), .VL_W(11), .ADDR_W(7)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int nrows_of(input int vl, input int sew);
        int s;
        s = (sew == 3) ? 2 : sew;
        return ((vl << s) + 31) / 32;
    endfunction

    function automatic logic [31:0] mask_of(input int vl, input int sew,
                                            input int row);
        int s, tb, n, lb;
        logic [63:0] one;
        s = (sew == 3) ? 2 : sew;
        tb = vl << s;
        n = nrows_of(vl, sew);
        if (row != n - 1) return 32'hFFFF_FFFF;
        lb = tb - (n - 1) * 32;
        one = 64'd1;
        return 32'((one << lb) - 64'd1);
    endfunction

    function automatic logic [31:0] row_addr(input int base, input int row);
        return 32'((base * RPR + row) % 128);
    endfunction

    // One operation starting in the current idle cycle; busy cycles are
    // counted in unstalled beats so each stall stretches by one cycle.
    task automatic run_op(input int vs1, input int vs2, input int vd,
                          input int vl, input int sew, input int st_at,
                          input int st_len, input bit poke);
        int n, busy, e, k;
        bit stl;
        n = nrows_of(vl, sew);
        busy = (vl == 0) ? 1 : n + PIPE_LAT;
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.vs1_i = 5'(vs1);
        bus.vs2_i = 5'(vs2);
        bus.vd_i = 5'(vd);
        bus.vl_i = 11'(vl);
        bus.sew_i = 2'(sew);
        bus.stall_i = 1'b0;
        #1 chk("rdy_idle", 32'(bus.port_rdy_o), 32'd1);
        e = 0;
        k = 0;
        while (e < busy) begin
            k++;
            @(negedge clk);
            bus.start_i = poke && (k == 2);
            if (poke && k == 2) begin
                bus.vs1_i = 5'($urandom_range(0, 31));
                bus.vd_i = 5'($urandom_range(0, 31));
                bus.vl_i = 11'($urandom_range(1, 300));
            end
            stl = (k >= st_at) && (k < st_at + st_len);
            bus.stall_i = stl;
            #1;
            if (!stl) e++;
            chk("rdy_busy", 32'(bus.port_rdy_o), 32'd0);
            if (!stl && e <= n) begin
                chk("rd_vld", 32'(bus.rd_vld_o), 32'd1);
                chk("rd_vs1", 32'(bus.rd_vs1_addr_o), row_addr(vs1, e - 1));
                chk("rd_vs2", 32'(bus.rd_vs2_addr_o), row_addr(vs2, e - 1));
            end else begin
                chk("rd_vld", 32'(bus.rd_vld_o), 32'd0);
            end
            if (!stl && e > PIPE_LAT && e <= n + PIPE_LAT) begin
                chk("wr_vld", 32'(bus.wr_vld_o), 32'd1);
                chk("wr_addr", 32'(bus.wr_addr_o),
                    row_addr(vd, e - 1 - PIPE_LAT));
                chk("wr_mask", bus.wr_bmask_o,
                    mask_of(vl, sew, e - 1 - PIPE_LAT));
            end else begin
                chk("wr_vld", 32'(bus.wr_vld_o), 32'd0);
                chk("wr_mask", bus.wr_bmask_o, 32'd0);
            end
        end
        bus.start_i = 1'b0;
        bus.stall_i = 1'b0;
    endtask

    initial begin
        bus.start_i = 1'b0;
        bus.vs1_i = '0;
        bus.vs2_i = '0;
        bus.vd_i = '0;
        bus.vl_i = '0;
        bus.sew_i = '0;
        bus.stall_i = 1'b0;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_rdy", 32'(bus.port_rdy_o), 32'd1);
        chk("rst_rd_vld", 32'(bus.rd_vld_o), 32'd0);
        chk("rst_rd_vs1", 32'(bus.rd_vs1_addr_o), 32'd0);
        chk("rst_rd_vs2", 32'(bus.rd_vs2_addr_o), 32'd0);
        chk("rst_wr_vld", 32'(bus.wr_vld_o), 32'd0);
        chk("rst_wr_addr", 32'(bus.wr_addr_o), 32'd0);
        chk("rst_wr_mask", bus.wr_bmask_o, 32'd0);
        rstn = 1'b1;

        run_op(1, 2, 3, 16, 2, 0, 0, 1'b0);
        run_op(5, 6, 0, 40, 0, 0, 0, 1'b0);
        run_op(7, 8, 31, 64, 2, 0, 0, 1'b0);
        run_op(1, 2, 3, 24, 2, 2, 2, 1'b0);
        run_op(0, 0, 0, 0, 1, 0, 0, 1'b0);
        run_op(4, 9, 10, 20, 1, 0, 0, 1'b1);
        run_op(30, 31, 29, 100, 3, 3, 1, 1'b0);

        for (int i = 0; i < 25; i++) begin
            int vl;
            vl = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 8)
                                             : $urandom_range(1, 200);
            run_op($urandom_range(0, 31), $urandom_range(0, 31),
                   $urandom_range(0, 31), vl, $urandom_range(0, 3),
                   $urandom_range(1, 6), $urandom_range(0, 3),
                   1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        #1 chk("rdy_final", 32'(bus.port_rdy_o), 32'd1);

        // Abort during READ
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.vs1_i = 5'd2;
        bus.vs2_i = 5'd3;
        bus.vd_i = 5'd4;
        bus.vl_i = 11'd64;
        bus.sew_i = 2'd2;
        #1 chk("mid_rdy", 32'(bus.port_rdy_o), 32'd1);
        @(negedge clk);
        bus.start_i = 1'b0;
        #1 chk("mid_rd1", 32'(bus.rd_vld_o), 32'd1);
        @(negedge clk);
        rstn = 1'b0;
        #1 chk("mid_rd2", 32'(bus.rd_vld_o), 32'd1);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("abort_rdy", 32'(bus.port_rdy_o), 32'd1);
        chk("abort_wr", 32'(bus.wr_vld_o), 32'd0);
        chk("abort_rd", 32'(bus.rd_vld_o), 32'd0);
        repeat (6) begin
            @(negedge clk);
            #1;
            chk("post_rdy", 32'(bus.port_rdy_o), 32'd1);
            chk("post_rd", 32'(bus.rd_vld_o), 32'd0);
            chk("post_wr", 32'(bus.wr_vld_o), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/v_port_group_sequencer.md
# v_port_group_sequencer

One sequencer per write-port group of the vector core. It accepts a `start_i` pulse from the port allocation logic together with the decoded operand registers, `vl` and SEW. It walks the VRF rows of the operand register group, issuing one read-address beat per row, and issues the matching write-address beat with a byte mask `PIPE_LAT` beats later. Its `port_rdy_o` is the per-group ready that the allocator samples: high only when the group is idle.

## Interface
Parameters:
- `LANES`, 8: number of 32-bit lanes. Row width `ROW_BYTES = LANES*4`.
- `VLEN`, 1024: vector register length in bits. `ROWS_PER_REG = VLEN/(8*ROW_BYTES)`, 4 at defaults.
- `PIPE_LAT`, 3: lane pipeline depth, in beats, from read address to write address.
- `VL_W`, 11: width of `vl_i`. Maximum `vl` is 1024.
- `ADDR_W`, `$clog2(32*ROWS_PER_REG)`: VRF row address width, 7 at defaults.

Ports:
- `clk`  in  1: clock.
- `rstn`  in  1: reset, synchronous, active-low.
- `start_i`  in  1: start request. Accepted only when `port_rdy_o`=1.
- `vs1_i`, `vs2_i`, `vd_i`  in  5 each: base registers of the operand groups.
- `vl_i`  in  `VL_W`: element count.
- `sew_i`  in  2: element width; 0=8, 1=16, 2=32 bits. Value 3 is treated as 2.
- `stall_i`  in  1: lane backpressure. Freezes the whole sequencer while high.
- `port_rdy_o`  out  1: group idle.
- `rd_vld_o`  out  1: read beat valid.
- `rd_vs1_addr_o`, `rd_vs2_addr_o`  out  `ADDR_W`: read row addresses.
- `wr_vld_o`  out  1: write beat valid.
- `wr_addr_o`  out  `ADDR_W`: write row address.
- `wr_bmask_o`  out  `ROW_BYTES`: byte enables for the write beat.

## Operation
- States are IDLE, READ and DRAIN. Reset puts the block in IDLE with `port_rdy_o`=1 and every other output 0.
- **IDLE:** `port_rdy_o`=1. On `start_i`, latch the operands and compute:
  - total bytes `tb = vl_i << sew`;
  - row count `nrows = ceil(tb/ROW_BYTES)`;
  - last-row byte count `lb = tb - (nrows-1)*ROW_BYTES`.
- **IDLE exits:**
  - If `vl_i`=0, go to DRAIN with no beats issued.
  - Otherwise go to READ with the row counter `r`=0.
- **READ:** each cycle with `stall_i`=0:
  - `rd_vld_o`=1;
  - `rd_vsX_addr_o = (vsX*ROWS_PER_REG + r) mod 2^ADDR_W`. Register groups wrap past v31 to v0.
  - Increment `r`. After beat `nrows-1`, go to DRAIN.
- **Write side:** a `PIPE_LAT`-deep valid/row/last shift register follows the read beats.
  - It advances only when `stall_i`=0.
  - `wr_addr_o` is formed from `vd` the same way the read addresses are formed from `vs1`/`vs2`.
  - `wr_bmask_o` is all ones, except on the last row, where only the low `lb` bits are set.
  - `wr_bmask_o` is 0 whenever `wr_vld_o`=0.
- **DRAIN:** stays here until the shift register is empty, then returns to IDLE.
- **Stall:** while `stall_i`=1 all valid outputs are driven 0 and all state, counters and the shift register hold.
- **Reset mid-operation:** aborts the operation, clears the shift register and returns to IDLE the next cycle.

## Timing
- `start_i` is accepted at edge T. Then:
  - `port_rdy_o` is 0 from T+1;
  - the first `rd_vld_o` is at T+1;
  - the last read beat is at T+`nrows` (no stalls);
  - the first `wr_vld_o` is at T+1+`PIPE_LAT`;
  - the last `wr_vld_o` is at T+`nrows`+`PIPE_LAT`;
  - `port_rdy_o` returns to 1 the following cycle.
- Total busy time without stalls is `nrows+PIPE_LAT` cycles. Each stalled cycle adds exactly one cycle.
- `vl`=0: `port_rdy_o` is low for exactly 1 cycle. No read or write beats are issued.
- `start_i` while `port_rdy_o`=0 is ignored. There is no queueing.
- A new start is accepted in the same cycle `port_rdy_o` is observed high (back-to-back). `port_rdy_o` is never high while a write beat is pending.

## Test plan
- **sew=2 (32-bit), vl=16, vs1=1, vs2=2, vd=3:**
  - 2 read beats, rows 4,5 / 8,9;
  - writes to rows 12,13 with mask 0xFFFFFFFF both beats;
  - `port_rdy_o` low for 5 cycles.
- **sew=0 (8-bit), vl=40, vd=0:**
  - `nrows`=2, `lb`=8;
  - writes to rows 0 (mask 0xFFFFFFFF) and 1 (mask 0x000000FF).
- **Wrap-around, vd=31, sew=2, vl=64 (8 rows):** write rows 124..127 then 0..3.
- **Stall, vl=24 sew=2:** `stall_i` high for 2 cycles after the first read beat. Read beats pause, write timing shifts by 2, and the busy time is 8 cycles.
- **Zero and back-to-back:** start with vl=0 gives `port_rdy_o` low for 1 cycle with no beats. A start asserted the cycle `port_rdy_o` returns high begins immediately. A start asserted while busy is ignored.
- **Reset mid-operation:** `rstn`=0 during READ gives `port_rdy_o`=1 and `wr_vld_o`=0 the next cycle, and no further beats.
